// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and counter direction type for the PWM block
package pwm_pkg;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;
  typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/pwm_cmp.sv
// pwm_cmp: one PWM channel holding its active duty, comparing against the shared timer
module pwm_cmp
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             apply,
  input  logic [WIDTH-1:0] timer,
  input  logic [WIDTH-1:0] duty_new,
  output logic             pwm
);
  logic [WIDTH-1:0] duty_act;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm <= en && (timer < duty_act);
      if (apply) duty_act <= duty_new;
    end
  end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shadowed period/duty; PWM_CENTER_EN selects up/down counting
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [WIDTH-1:0]          timer,
  output logic                      wrap,
  output logic                      upd_pending
);
  logic [WIDTH-1:0]          period_act, period_pend, timer_nxt;
  logic [CHANNELS*WIDTH-1:0] duty_pend;
  logic                      bnd, apply;
  // a pending set lands either at the period boundary or immediately while disabled
  assign apply = upd_pending && (!en || bnd);
`ifdef PWM_CENTER_EN
  dir_t dir, dir_nxt;
  assign bnd = (period_act == '0) || (dir == DOWN && timer == '0);
  always_comb begin
    dir_nxt   = dir;
    timer_nxt = timer;
    if (!en || period_act == '0) begin
      timer_nxt = '0;
      dir_nxt   = UP;
    end else if (bnd) begin
      timer_nxt = (apply && period_pend == '0) ? '0 : WIDTH'(1);
      dir_nxt   = UP;
    end else if (dir == UP && timer == period_act) begin
      timer_nxt = timer - WIDTH'(1);
      dir_nxt   = DOWN;
    end else begin
      timer_nxt = (dir == UP) ? timer + WIDTH'(1) : timer - WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dir <= UP;
    else       dir <= dir_nxt;
  end
`else
  assign bnd       = (timer == period_act);
  assign timer_nxt = (!en || bnd) ? '0 : timer + WIDTH'(1);
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer       <= '0;
      wrap        <= 1'b0;
      upd_pending <= 1'b0;
      period_act  <= '0;
      period_pend <= '0;
      duty_pend   <= '0;
    end else begin
      timer       <= timer_nxt;
      wrap        <= en && bnd;
      upd_pending <= load || (upd_pending && !apply);
      if (apply) period_act <= period_pend;
      if (load) begin
        period_pend <= period;
        duty_pend   <= duty;
      end
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .apply    (apply),
      .timer    (timer),
      .duty_new (duty_pend[c*WIDTH +: WIDTH]),
      .pwm      (pwm_out[c])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi against a phase-based reference model
module tb_pwm_multi;
  localparam int W = 16;
  localparam int C = 4;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic [W-1:0]   period = '0;
  logic [C*W-1:0] duty = '0;
  logic [C-1:0]   pwm_out;
  logic [W-1:0]   timer;
  logic           wrap, upd_pending;
  int vecs = 0;
  int errs = 0;
  int m_pa, m_pp, m_ph;
  int m_da[C];
  int m_dp[C];
  bit m_pend, m_wrap, m_fresh;
  bit [C-1:0] m_pwm;

  pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rstn(rstn), .en(en), .period(period), .duty(duty), .load(load),
    .pwm_out(pwm_out), .timer(timer), .wrap(wrap), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  function automatic int m_timer();
`ifdef PWM_CENTER_EN
    return (m_ph <= m_pa) ? m_ph : 2 * m_pa - m_ph;
`else
    return m_ph;
`endif
  endfunction

  function automatic bit m_bnd();
`ifdef PWM_CENTER_EN
    return (m_pa == 0) || (m_ph == 0 && !m_fresh);
`else
    return m_ph == m_pa;
`endif
  endfunction

  task automatic m_reset();
    m_pa = 0; m_pp = 0; m_ph = 0; m_pend = 0; m_wrap = 0; m_fresh = 1; m_pwm = '0;
    for (int i = 0; i < C; i++) begin m_da[i] = 0; m_dp[i] = 0; end
  endtask

  task automatic m_step();
    bit b, ap;
    int t, opa;
    b = m_bnd();
    ap = m_pend && (!en || b);
    t = m_timer();
    opa = m_pa;
    for (int i = 0; i < C; i++) m_pwm[i] = en && (t < m_da[i]);
    m_wrap = en && b;
    if (ap) begin m_pa = m_pp; m_da = m_dp; end
    if (load) begin
      m_pp = int'(period);
      for (int i = 0; i < C; i++) m_dp[i] = int'(duty[i*W +: W]);
    end
    m_pend = load || (m_pend && !ap);
`ifdef PWM_CENTER_EN
    if (!en || opa == 0) begin m_ph = 0; m_fresh = 1; end
    else if (b) begin m_ph = (m_pa == 0) ? 0 : 1; m_fresh = (m_pa == 0); end
    else begin m_ph = (m_ph + 1) % (2 * m_pa); m_fresh = 0; end
`else
    m_ph = (!en || b) ? 0 : m_ph + 1;
`endif
  endtask

  task automatic chk();
    int t;
    t = m_timer();
    vecs++;
    if (timer !== W'(t)) begin errs++; $display("FAIL timer: got %0d expected %0d at %0t", timer, t, $time); end
    vecs++;
    if (wrap !== m_wrap) begin errs++; $display("FAIL wrap: got %b expected %b at %0t", wrap, m_wrap, $time); end
    vecs++;
    if (pwm_out !== m_pwm) begin errs++; $display("FAIL pwm_out: got %b expected %b at %0t", pwm_out, m_pwm, $time); end
    vecs++;
    if (upd_pending !== m_pend) begin errs++; $display("FAIL upd_pending: got %b expected %b at %0t", upd_pending, m_pend, $time); end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    chk();
  endtask

  task automatic wait_timer(input int v);
    int n = 0;
    while (timer !== W'(v) && n < 200) begin cyc(); n++; end
    vecs++;
    if (timer !== W'(v)) begin errs++; $display("FAIL wait_timer: timer %0d never reached %0d", timer, v); end
  endtask

  task automatic test_reset();
    m_reset();
    #12;
    chk();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int h0, h1, h2, nw;
    h0 = 0; h1 = 0; h2 = 0; nw = 0;
    period = W'(9);
    duty = {W'(5), W'(10), W'(0), W'(3)};
    load = 1'b1;
    cyc();
    load = 1'b0;
    vecs++;
    if (upd_pending !== 1'b1) begin errs++; $display("FAIL basic_pending_set: got %b expected 1", upd_pending); end
    cyc();
    vecs++;
    if (upd_pending !== 1'b0) begin errs++; $display("FAIL basic_pending_apply: got %b expected 0", upd_pending); end
    en = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    for (int k = 0; k < 30; k++) begin
      cyc();
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]); nw += int'(wrap);
    end
`ifndef PWM_CENTER_EN
    vecs++;
    if (h0 != 9) begin errs++; $display("FAIL basic_ch0_high: got %0d expected 9", h0); end
    vecs++;
    if (h1 != 0) begin errs++; $display("FAIL basic_ch1_low: got %0d expected 0", h1); end
    vecs++;
    if (h2 != 30) begin errs++; $display("FAIL basic_ch2_high: got %0d expected 30", h2); end
    vecs++;
    if (nw != 3) begin errs++; $display("FAIL basic_wrap_count: got %0d expected 3", nw); end
`endif
  endtask

  task automatic test_midload();
    int n, h;
    n = 0; h = 0;
    wait_timer(4);
    duty[W-1:0] = W'(7);
    load = 1'b1;
    cyc();
    load = 1'b0;
    while (wrap !== 1'b1 && n < 50) begin
      vecs++;
      if (upd_pending !== 1'b1) begin errs++; $display("FAIL midload_pending: got %b expected 1", upd_pending); end
      cyc();
      n++;
    end
    vecs++;
    if (wrap !== 1'b1) begin errs++; $display("FAIL midload_wrap_timeout: wrap %b expected 1", wrap); end
    vecs++;
    if (upd_pending !== 1'b0) begin errs++; $display("FAIL midload_pending_clear: got %b expected 0", upd_pending); end
    for (int k = 0; k < 10; k++) begin
      h += int'(pwm_out[0]);
      cyc();
    end
`ifndef PWM_CENTER_EN
    vecs++;
    if (h != 7) begin errs++; $display("FAIL midload_new_duty: got %0d expected 7", h); end
`endif
  endtask

  task automatic test_boundary_load();
    int h_old, h_new;
    h_old = 0; h_new = 0;
    wait_timer(9);
    duty[W-1:0] = W'(2);
    load = 1'b1;
    cyc();
    load = 1'b0;
    vecs++;
    if (upd_pending !== 1'b1) begin errs++; $display("FAIL bndload_pending: got %b expected 1", upd_pending); end
    for (int k = 0; k < 10; k++) begin h_old += int'(pwm_out[0]); cyc(); end
    for (int k = 0; k < 10; k++) begin h_new += int'(pwm_out[0]); cyc(); end
`ifndef PWM_CENTER_EN
    vecs++;
    if (h_old != 7) begin errs++; $display("FAIL bndload_old_period: got %0d expected 7", h_old); end
    vecs++;
    if (h_new != 2) begin errs++; $display("FAIL bndload_new_period: got %0d expected 2", h_new); end
`endif
  endtask

`ifdef PWM_CENTER_EN
  task automatic test_center();
    int seq[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int nw, prev;
    bit exp_p;
    nw = 0;
    en = 1'b0;
    period = W'(4);
    duty = {W'(0), W'(0), W'(0), W'(2)};
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cyc();
      prev = (k == 0) ? 0 : seq[(k - 1) % 8];
      exp_p = prev < 2;
      nw += int'(wrap);
      vecs++;
      if (timer !== W'(seq[k % 8])) begin errs++; $display("FAIL center_timer: got %0d expected %0d", timer, seq[k % 8]); end
      vecs++;
      if (pwm_out[0] !== exp_p) begin errs++; $display("FAIL center_pwm: got %b expected %b", pwm_out[0], exp_p); end
    end
    vecs++;
    if (nw != 2) begin errs++; $display("FAIL center_wrap_count: got %0d expected 2", nw); end
  endtask
`endif

  task automatic test_random();
    int p;
`ifdef PWM_CENTER_EN
    int lo = 1;
`else
    int lo = 0;
`endif
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(29, 0) == 0) en = ~en;
      load = ($urandom_range(11, 0) == 0);
      if (load) begin
        p = int'($urandom_range(12, lo));
        period = W'(p);
        for (int i = 0; i < C; i++) duty[i*W +: W] = W'($urandom_range(p + 2, 0));
      end
      cyc();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hi;
    hi = 0;
    en = 1'b1;
    period = W'(9);
    duty = {W'(4), W'(8), W'(1), W'(6)};
    load = 1'b1;
    cyc();
    load = 1'b0;
    wait_timer(4);
    duty = {W'(2), W'(2), W'(2), W'(2)};
    load = 1'b1;
    cyc();
    load = 1'b0;
    vecs++;
    if (timer !== W'(5) || upd_pending !== 1'b1) begin
      errs++; $display("FAIL rstmid_setup: timer %0d pending %b expected 5 and 1", timer, upd_pending);
    end
    #2 rstn = 1'b0;
    #1;
    vecs++;
    if (timer !== '0 || pwm_out !== '0 || wrap !== 1'b0 || upd_pending !== 1'b0) begin
      errs++; $display("FAIL rstmid_async: timer %0d pwm %b wrap %b pending %b expected all 0", timer, pwm_out, wrap, upd_pending);
    end
    m_reset();
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      hi += (pwm_out != '0) ? 1 : 0;
    end
    vecs++;
    if (hi != 0) begin errs++; $display("FAIL rstmid_outputs_low: %0d cycles with pwm high, expected 0", hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midload();
    test_boundary_load();
`ifdef PWM_CENTER_EN
    test_center();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
